pc_unit: RTL and testbench

- Parametrised program-counter unit that generalises the single-register PC.
- Holds the architectural PC and selects the next PC by fixed priority from these sources: exception, exception return, subroutine return, jump, branch, sequential.
- Adds an EPC capture register, a misaligned-target trap, and a small return-address stack (RAS) for call/return.
- Sits at the fetch stage of the multi-cycle CPU; PC_Addr drives instruction memory.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_ras.sv | 71 +++++++
 rtl/pc_unit.sv | 141 ++++++++++++++
 tb/tb_pc_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared definitions for the program-counter unit: the next-PC
//             source encoding and the default reset / exception vectors.
//  Revision : 1.0  initial release
// ============================================================================
package pc_pkg;

    // Source that produced the next PC on a given edge, highest priority last.
    typedef enum logic [2:0] {
        SRC_SEQ      = 3'd0,
        SRC_BR       = 3'd1,
        SRC_JMP      = 3'd2,
        SRC_RET      = 3'd3,
        SRC_ERET     = 3'd4,
        SRC_EXC      = 3'd5,
        SRC_MISALIGN = 3'd6
    } pc_src_e;

    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras
//  Purpose  : Circular return-address stack with a top pointer and a count.
//             A push when full overwrites the oldest entry. A simultaneous
//             push and pop replaces the top entry in place.
//  Ports    : clk, rst_n (sync, active high)
//             push, pop, push_data  - stack operations for this edge
//             top                   - entry at the top pointer
//             empty, full           - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop_ok;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;

    // A pop on an empty stack is discarded so the count can never underflow.
    assign w_pop_ok  = pop && !empty;
    // Depth is a power of two, so pointer arithmetic wraps naturally.
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr - 1'b1;

    assign top   = r_mem[r_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push && w_pop_ok) begin
            // Pop then push: the top slot is overwritten, depth is unchanged.
            r_mem[r_ptr] <= push_data;
        end else if (push) begin
            r_mem[w_ptr_inc] <= push_data;
            r_ptr            <= w_ptr_inc;
            if (!full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop_ok) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Fetch-stage program counter. Selects the next PC by fixed
//             priority (exception, eret, ret, jump, branch, sequential),
//             captures EPC on traps, traps misaligned targets, and keeps a
//             return-address stack for call/return.
//  Ports    : clk, rst_n (sync, active high despite the name)
//             PC_enable      - update strobe, low stalls the PC
//             branch_taken / branch_target, jump / jump_target, call
//             ret / ret_target (fallback when the stack is empty)
//             exception, eret
//             PC_Addr, PC_plus4, EPC, misalign (one-cycle pulse)
//             ras_empty, ras_full
//  Revision : 1.0  initial release
// ============================================================================
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(pc_pkg::RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(pc_pkg::EXC_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PC_enable,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    input  logic [XLEN-1:0] ret_target,
    input  logic            exception,
    input  logic            eret,
    output logic [XLEN-1:0] PC_Addr,
    output logic [XLEN-1:0] PC_plus4,
    output logic [XLEN-1:0] EPC,
    output logic            misalign,
    output logic            ras_empty,
    output logic            ras_full
);

    import pc_pkg::*;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_misalign;

    logic            w_update;
    pc_src_e         w_src;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_push;
    logic            w_ras_pop;

    assign PC_Addr  = r_pc;
    assign PC_plus4 = r_pc + XLEN'(4);
    assign EPC      = r_epc;
    assign misalign = r_misalign;

    // An exception is taken even while the pipeline is stalled.
    assign w_update = PC_enable || exception;

    // Priority selection followed by the alignment check on redirect targets.
    always_comb begin
        w_src    = SRC_SEQ;
        w_target = PC_plus4;
        if (exception) begin
            w_src    = SRC_EXC;
            w_target = EXC_VEC;
        end else if (eret) begin
            w_src    = SRC_ERET;
            w_target = r_epc;
        end else if (ret) begin
            w_src    = SRC_RET;
            w_target = ras_empty ? ret_target : w_ras_top;
        end else if (jump) begin
            w_src    = SRC_JMP;
            w_target = jump_target;
        end else if (branch_taken) begin
            w_src    = SRC_BR;
            w_target = branch_target;
        end

        // The sequential path stays aligned by construction and is not checked.
        if (w_src != SRC_SEQ && w_src != SRC_EXC && w_target[1:0] != 2'b00) begin
            w_src = SRC_MISALIGN;
        end
    end

    assign w_next_pc = (w_src == SRC_EXC || w_src == SRC_MISALIGN) ? EXC_VEC : w_target;

    // A misaligned redirect suppresses all stack activity on that edge.
    // ret with jump+call replaces the top entry only when the ret actually
    // popped; an empty-stack return leaves the stack untouched.
    always_comb begin
        w_ras_pop  = 1'b0;
        w_ras_push = 1'b0;
        if (w_update) begin
            if (w_src == SRC_RET) begin
                w_ras_pop  = !ras_empty;
                w_ras_push = !ras_empty && jump && call;
            end else if (w_src == SRC_JMP) begin
                w_ras_push = call;
            end
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_ras_push),
        .pop       (w_ras_pop),
        .push_data (PC_plus4),
        .top       (w_ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_update && (w_src == SRC_MISALIGN);
            if (w_update) begin
                r_pc <= w_next_pc;
                if (w_src == SRC_EXC || w_src == SRC_MISALIGN) begin
                    r_epc <= r_pc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed self-checking bench for pc_unit with hand-computed
//             expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        PC_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        call;
    logic        ret;
    logic [31:0] ret_target;
    logic        exception;
    logic        eret;
    logic [31:0] PC_Addr;
    logic [31:0] PC_plus4;
    logic [31:0] EPC;
    logic        misalign;
    logic        ras_empty;
    logic        ras_full;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_3000),
        .EXC_VEC   (32'h0000_4180),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_enable     (PC_enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .ret_target    (ret_target),
        .exception     (exception),
        .eret          (eret),
        .PC_Addr       (PC_Addr),
        .PC_plus4      (PC_plus4),
        .EPC           (EPC),
        .misalign      (misalign),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 ns after it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PC_enable     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        call          = 1'b0;
        ret           = 1'b0;
        ret_target    = '0;
        exception     = 1'b0;
        eret          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
    endtask

    // One enabled call: jump to target while pushing PC+4.
    task automatic do_call(input logic [31:0] tgt);
        clear_inputs();
        PC_enable   = 1'b1;
        jump        = 1'b1;
        call        = 1'b1;
        jump_target = tgt;
        step();
    endtask

    task automatic do_ret(input logic [31:0] fallback);
        clear_inputs();
        PC_enable  = 1'b1;
        ret        = 1'b1;
        ret_target = fallback;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h0000_3404;
        exp_ret[1] = 32'h0000_3304;
        exp_ret[2] = 32'h0000_3204;
        exp_ret[3] = 32'h0000_3104;

        // ---------------- reset state ----------------
        clear_inputs();
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        check("rst_pc",     PC_Addr,   32'h0000_3000);
        check("rst_plus4",  PC_plus4,  32'h0000_3004);
        check("rst_epc",    EPC,       32'h0);
        check("rst_mis",    {31'b0, misalign},  32'h0);
        check("rst_empty",  {31'b0, ras_empty}, 32'h1);
        check("rst_full",   {31'b0, ras_full},  32'h0);

        // ---------------- sequential and stall ----------------
        PC_enable = 1'b1;
        step(); check("seq1", PC_Addr, 32'h0000_3004);
        step(); check("seq2", PC_Addr, 32'h0000_3008);
        step(); check("seq3", PC_Addr, 32'h0000_300C);
        PC_enable = 1'b0;
        step(); check("stall1", PC_Addr, 32'h0000_300C);
        step(); check("stall2", PC_Addr, 32'h0000_300C);

        // ---------------- jump beats branch; misaligned branch ----------------
        PC_enable = 1'b1;
        step(); check("seq4", PC_Addr, 32'h0000_3010);
        jump = 1'b1; jump_target = 32'h0000_3100;
        branch_taken = 1'b1; branch_target = 32'h0000_3200;
        step(); check("jmp_over_br", PC_Addr, 32'h0000_3100);
        jump = 1'b0; branch_target = 32'h0000_3002;
        step();
        check("mis_pc",  PC_Addr, 32'h0000_4180);
        check("mis_epc", EPC,     32'h0000_3100);
        check("mis_hi",  {31'b0, misalign}, 32'h1);
        clear_inputs();
        step();
        check("mis_lo",   {31'b0, misalign}, 32'h0);
        check("mis_hold", PC_Addr, 32'h0000_4180);

        // ---------------- exception during stall, then eret ----------------
        PC_enable = 1'b1; jump = 1'b1; jump_target = 32'h0000_3008;
        step(); check("jmp_3008", PC_Addr, 32'h0000_3008);
        clear_inputs();
        exception = 1'b1;
        step();
        check("exc_pc",  PC_Addr, 32'h0000_4180);
        check("exc_epc", EPC,     32'h0000_3008);
        check("exc_mis", {31'b0, misalign}, 32'h0);
        clear_inputs();
        PC_enable = 1'b1; eret = 1'b1;
        step(); check("eret_pc", PC_Addr, 32'h0000_3008);

        // ---------------- RAS fill, overflow, drain, fallback ----------------
        do_reset();
        do_call(32'h0000_3100);
        do_call(32'h0000_3200);
        do_call(32'h0000_3300);
        check("ras_3_notfull", {31'b0, ras_full}, 32'h0);
        do_call(32'h0000_3400);
        check("ras_4_full", {31'b0, ras_full}, 32'h1);
        do_call(32'h0000_3500);
        check("ras_5_full", {31'b0, ras_full}, 32'h1);
        check("ras_5_pc",   PC_Addr, 32'h0000_3500);
        for (int i = 0; i < 4; i++) begin
            do_ret(32'h0000_3600);
            check($sformatf("ret%0d_pc", i), PC_Addr, exp_ret[i]);
        end
        check("ras_drained_empty", {31'b0, ras_empty}, 32'h1);
        do_ret(32'h0000_3500);
        check("ret_fallback", PC_Addr, 32'h0000_3500);
        check("ret_fb_empty", {31'b0, ras_empty}, 32'h1);

        // ---------------- ret together with jump+call ----------------
        do_reset();
        do_call(32'h0000_3100);                   // pushes 3004
        clear_inputs();
        PC_enable = 1'b1; ret = 1'b1; jump = 1'b1; call = 1'b1;
        jump_target = 32'h0000_3200; ret_target = 32'h0000_3700;
        step();                                   // pops 3004, pushes 3104
        check("retcall_pc",    PC_Addr, 32'h0000_3004);
        check("retcall_count", {31'b0, ras_empty}, 32'h0);
        do_ret(32'h0000_3700);
        check("retcall_top",   PC_Addr, 32'h0000_3104);
        check("retcall_empty", {31'b0, ras_empty}, 32'h1);

        // ---------------- call without jump is ignored ----------------
        clear_inputs();
        PC_enable = 1'b1; call = 1'b1;
        step();
        check("call_nojmp_pc",    PC_Addr, 32'h0000_3108);
        check("call_nojmp_empty", {31'b0, ras_empty}, 32'h1);

        // ---------------- address wrap ----------------
        clear_inputs();
        PC_enable = 1'b1; jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step(); check("wrap_top", PC_Addr, 32'hFFFF_FFFC);
        jump = 1'b0;
        step();
        check("wrap_pc",    PC_Addr,  32'h0000_0000);
        check("wrap_plus4", PC_plus4, 32'h0000_0004);

        // ---------------- reset beats exception ----------------
        do_reset();
        do_call(32'h0000_3100);
        do_call(32'h0000_3200);
        clear_inputs();
        exception = 1'b1;
        step();
        check("pre_rst_epc",   EPC, 32'h0000_3200);
        check("pre_rst_empty", {31'b0, ras_empty}, 32'h0);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        clear_inputs();
        check("rst_exc_pc",    PC_Addr, 32'h0000_3000);
        check("rst_exc_epc",   EPC,     32'h0);
        check("rst_exc_empty", {31'b0, ras_empty}, 32'h1);
        step();
        check("rst_exc_after", PC_Addr, 32'h0000_3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
